// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the 7x5 LED matrix pixel mux: steps the mux select, samples
// one pixel per position and swaps in a double-buffered frame at frame boundaries.
module matrix_scan_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [34:0] frame_in,
    input  logic        frame_load,
    input  logic        mux_bit,
    output logic [34:0] frame_out,
    output logic [5:0]  mux_sel,
    output logic        pixel_out,
    output logic        pos_valid,
    output logic [2:0]  row_idx,
    output logic [4:0]  col_onehot,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [7:0] TERM_CNT = 8'(TICK_DIV - 1);
    localparam logic [5:0] LAST_POS = 6'd34;
    localparam logic [5:0] BLANK    = 6'd63;

    state_t      state_q, state_d;
    logic [34:0] frame_q, frame_d;
    logic [34:0] pending_q, pending_d;
    logic        pend_flag_q, pend_flag_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  presc_q, presc_d;
    logic        pixel_q, pixel_d;
    logic        pos_valid_q, pos_valid_d;
    logic [2:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        do_swap;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        sel_d       = sel_q;
        presc_d     = presc_q;
        pixel_d     = pixel_q;
        pos_valid_d = 1'b0;
        row_d       = row_q;
        col_d       = col_q;
        done_d      = 1'b0;
        do_swap     = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = BLANK;
                if (start) begin
                    do_swap = 1'b1;
                    sel_d   = 6'd0;
                    presc_d = 8'd0;
                    state_d = SCAN;
                end
            end
            SCAN, DRAIN: begin
                if (state_q == SCAN && stop) begin
                    state_d = DRAIN;
                end
                if (presc_q == TERM_CNT) begin
                    presc_d     = 8'd0;
                    pixel_d     = mux_bit;
                    pos_valid_d = 1'b1;
                    row_d       = 3'(sel_q % 6'd7);
                    col_d       = 5'(5'd1 << (sel_q / 6'd7));
                    if (sel_q == LAST_POS) begin
                        done_d  = 1'b1;
                        do_swap = 1'b1;
                        // A stop landing exactly on the last position ends the scan here.
                        if (state_q == DRAIN || stop) begin
                            sel_d   = BLANK;
                            state_d = IDLE;
                        end else begin
                            sel_d = 6'd0;
                        end
                    end else begin
                        sel_d = sel_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = BLANK;
            end
        endcase

        if (do_swap && pend_flag_q) begin
            frame_d     = pending_q;
            pend_flag_d = 1'b0;
        end
        // A load on a swap cycle stays pending for the following boundary.
        if (frame_load) begin
            pending_d   = frame_in;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            sel_q       <= BLANK;
            presc_q     <= 8'd0;
            pixel_q     <= 1'b0;
            pos_valid_q <= 1'b0;
            row_q       <= 3'd0;
            col_q       <= 5'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            sel_q       <= sel_d;
            presc_q     <= presc_d;
            pixel_q     <= pixel_d;
            pos_valid_q <= pos_valid_d;
            row_q       <= row_d;
            col_q       <= col_d;
            done_q      <= done_d;
        end
    end

    assign frame_out  = frame_q;
    assign mux_sel    = sel_q;
    assign pixel_out  = pixel_q;
    assign pos_valid  = pos_valid_q;
    assign row_idx    = row_q;
    assign col_onehot = col_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: one instance at TICK_DIV=4 and one at
// TICK_DIV=1, each feeding its own behavioural 35:1 pixel mux.
module tb_matrix_scan_ctrl;

    localparam int LOG = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start = 1'b0, stop = 1'b0, frame_load = 1'b0, mux_bit;
    logic [34:0] frame_in = '0, frame_out;
    logic [5:0]  mux_sel;
    logic        pixel_out, pos_valid, frame_done, busy;
    logic [2:0]  row_idx;
    logic [4:0]  col_onehot;

    logic        start1 = 1'b0, stop1 = 1'b0, frame_load1 = 1'b0, mux_bit1;
    logic [34:0] frame_in1 = '0, frame_out1;
    logic [5:0]  mux_sel1;
    logic        pixel_out1, pos_valid1, frame_done1, busy1;
    logic [2:0]  row_idx1;
    logic [4:0]  col_onehot1;

    int tests_run = 0;
    int tests_failed = 0;

    int cyc, pv_cnt, done_cnt, pv1_cnt, done1_cnt;
    logic       pix_log [LOG];
    logic [2:0] row_log [LOG];
    logic [4:0] col_log [LOG];
    int         pv_cyc [LOG];
    int         done_cyc [8];
    logic       pix1_log [LOG];
    int         pv1_cyc [LOG];
    int         done1_cyc [8];
    int         done1_pv [8];

    typedef struct {
        logic [34:0] frame;
        int          pos;
        logic        pix;
        logic [2:0]  row;
        logic [4:0]  col;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    // Behavioural 35:1 mux: select s routes A[34-s], out-of-range selects read 0.
    assign mux_bit  = (mux_sel  < 6'd35) ? frame_out[6'd34 - mux_sel]   : 1'b0;
    assign mux_bit1 = (mux_sel1 < 6'd35) ? frame_out1[6'd34 - mux_sel1] : 1'b0;

    matrix_scan_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .frame_in(frame_in), .frame_load(frame_load), .mux_bit(mux_bit),
        .frame_out(frame_out), .mux_sel(mux_sel), .pixel_out(pixel_out),
        .pos_valid(pos_valid), .row_idx(row_idx), .col_onehot(col_onehot),
        .frame_done(frame_done), .busy(busy)
    );

    matrix_scan_ctrl #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1),
        .frame_in(frame_in1), .frame_load(frame_load1), .mux_bit(mux_bit1),
        .frame_out(frame_out1), .mux_sel(mux_sel1), .pixel_out(pixel_out1),
        .pos_valid(pos_valid1), .row_idx(row_idx1), .col_onehot(col_onehot1),
        .frame_done(frame_done1), .busy(busy1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [34:0] f, input logic ld, input logic st, input logic sp);
        frame_in   = f;
        frame_load = ld;
        start      = st;
        stop       = sp;
    endtask

    // Advance one cycle and log every strobe from both instances.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pos_valid) begin
            if (pv_cnt < LOG) begin
                pix_log[pv_cnt] = pixel_out;
                row_log[pv_cnt] = row_idx;
                col_log[pv_cnt] = col_onehot;
                pv_cyc[pv_cnt]  = cyc;
            end
            pv_cnt++;
        end
        if (frame_done) begin
            if (done_cnt < 8) done_cyc[done_cnt] = cyc;
            done_cnt++;
        end
        if (pos_valid1) begin
            if (pv1_cnt < LOG) begin
                pix1_log[pv1_cnt] = pixel_out1;
                pv1_cyc[pv1_cnt]  = cyc;
            end
            pv1_cnt++;
        end
        if (frame_done1) begin
            if (done1_cnt < 8) begin
                done1_cyc[done1_cnt] = cyc;
                done1_pv[done1_cnt]  = pv1_cnt;
            end
            done1_cnt++;
        end
    endtask

    task automatic clearLog();
        cyc = 0; pv_cnt = 0; done_cnt = 0; pv1_cnt = 0; done1_cnt = 0;
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Reset, load a frame, start, and leave the log aligned to the start edge.
    task automatic loadAndStart(input logic [34:0] f);
        doReset();
        applyStimulus(f, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(f, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(f, 1'b0, 1'b0, 1'b0);
        clearLog();
    endtask

    function automatic int countOnes(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (pix_log[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    initial begin
        vecs[0] = '{35'h4_0000_0001,  0, 1'b1, 3'd0, 5'b00001};
        vecs[1] = '{35'h4_0000_0001, 34, 1'b1, 3'd6, 5'b10000};
        vecs[2] = '{35'h4_0000_0001, 17, 1'b0, 3'd3, 5'b00100};
        vecs[3] = '{35'h5_5555_5555,  8, 1'b1, 3'd1, 5'b00010};
        vecs[4] = '{35'h5_5555_5555,  1, 1'b0, 3'd1, 5'b00001};
        vecs[5] = '{35'h0_0000_8000, 19, 1'b1, 3'd5, 5'b00100};
        vecs[6] = '{35'h0_0000_8000, 20, 1'b0, 3'd6, 5'b00100};

        clearLog();
        step();
        checkOutput("rst_frame_out", 64'(frame_out), 64'h0);
        checkOutput("rst_mux_sel", 64'(mux_sel), 64'd63);
        checkOutput("rst_outputs", 64'({pixel_out, pos_valid, row_idx, col_onehot, frame_done, busy}), 64'h0);
        checkOutput("rst_mux_sel1", 64'(mux_sel1), 64'd63);
        reset = 1'b0;
        step();

        // Table-driven single-frame captures
        for (int v = 0; v < 7; v++) begin
            loadAndStart(vecs[v].frame);
            for (int k = 0; k < 200 && done_cnt == 0; k++) step();
            checkOutput($sformatf("v%0d_frame_done_seen", v), 64'(done_cnt != 0), 64'd1);
            checkOutput($sformatf("v%0d_pixel", v), 64'(pix_log[vecs[v].pos]), 64'(vecs[v].pix));
            checkOutput($sformatf("v%0d_row", v), 64'(row_log[vecs[v].pos]), 64'(vecs[v].row));
            checkOutput($sformatf("v%0d_col", v), 64'(col_log[vecs[v].pos]), 64'(vecs[v].col));
            checkOutput($sformatf("v%0d_first_pv_cycle", v), 64'(pv_cyc[0]), 64'd4);
            checkOutput($sformatf("v%0d_done_cycle", v), 64'(done_cyc[0]), 64'd140);
        end

        // Double buffering: loads mid-frame, last one wins, swap only at the boundary
        loadAndStart(35'h0_0000_0001);
        for (int k = 0; k < 200 && mux_sel != 6'd8; k++) step();
        applyStimulus(35'h0_0000_00FF, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 200 && mux_sel != 6'd10; k++) step();
        applyStimulus(35'h7_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(35'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("dbuf_mid_frame_hold", 64'(frame_out), 64'h1);
        for (int k = 0; k < 200 && done_cnt < 1; k++) step();
        checkOutput("dbuf_swap_at_boundary", 64'(frame_out), 64'h7_FFFF_FFFF);
        checkOutput("dbuf_old_frame_ones", 64'(countOnes(0, 34)), 64'd1);
        checkOutput("dbuf_old_frame_pos34", 64'(pix_log[34]), 64'd1);
        for (int k = 0; k < 200 && pv_cnt < 70; k++) step();
        checkOutput("dbuf_new_frame_ones", 64'(countOnes(35, 69)), 64'd35);
        checkOutput("dbuf_next_frame_latency", 64'(pv_cyc[35] - done_cyc[0]), 64'd4);
        checkOutput("dbuf_busy_scanning", 64'(busy), 64'd1);

        // Stop mid-frame drains the rest of the frame
        loadAndStart(35'h4_0000_0001);
        for (int k = 0; k < 200 && pv_cnt < 21; k++) step();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("stop_drain_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 200 && done_cnt < 1; k++) step();
        checkOutput("stop_further_pv", 64'(pv_cnt - 21), 64'd14);
        checkOutput("stop_busy_low", 64'(busy), 64'd0);
        checkOutput("stop_mux_blank", 64'(mux_sel), 64'd63);
        for (int k = 0; k < 10; k++) step();
        checkOutput("stop_no_restart", 64'(pv_cnt), 64'd35);

        // Stop coincident with the last position's terminal count
        loadAndStart(35'h4_0000_0001);
        for (int k = 0; k < 200 && cyc < 139; k++) step();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("stop34_done", 64'(done_cnt), 64'd1);
        checkOutput("stop34_busy", 64'(busy), 64'd0);
        checkOutput("stop34_mux_blank", 64'(mux_sel), 64'd63);
        for (int k = 0; k < 8; k++) step();
        checkOutput("stop34_no_pos0", 64'(pv_cnt), 64'd35);

        // Asynchronous reset mid-frame discards active and pending frames
        loadAndStart(35'h4_0000_0001);
        for (int k = 0; k < 200 && mux_sel != 6'd5; k++) step();
        applyStimulus(35'h7_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 200 && mux_sel != 6'd17; k++) step();
        reset = 1'b1;
        #1;
        checkOutput("arst_frame_out", 64'(frame_out), 64'h0);
        checkOutput("arst_mux_sel", 64'(mux_sel), 64'd63);
        checkOutput("arst_outputs", 64'({pixel_out, pos_valid, row_idx, col_onehot, frame_done, busy}), 64'h0);
        step();
        reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        clearLog();
        for (int k = 0; k < 200 && pv_cnt < 35; k++) step();
        checkOutput("arst_resume_count", 64'(pv_cnt), 64'd35);
        checkOutput("arst_resume_ones", 64'(countOnes(0, 34)), 64'd0);
        checkOutput("arst_resume_pos0", 64'({row_log[0], col_log[0]}), 64'({3'd0, 5'b00001}));
        checkOutput("arst_resume_latency", 64'(pv_cyc[0]), 64'd4);
        checkOutput("arst_frame_out_zero", 64'(frame_out), 64'h0);

        // TICK_DIV=1: one position per cycle, continuous strobe
        frame_in1 = 35'h5_5555_5555;
        frame_load1 = 1'b1;
        step();
        frame_load1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        clearLog();
        for (int k = 0; k < 300 && done1_cnt < 3; k++) step();
        checkOutput("t1_done_seen", 64'(done1_cnt >= 3), 64'd1);
        checkOutput("t1_first_pv", 64'(pv1_cyc[0]), 64'd1);
        for (int i = 0; i < 35; i++)
            checkOutput($sformatf("t1_pix%0d", i), 64'(pix1_log[i]), 64'((i % 2) == 0));
        checkOutput("t1_done_period_a", 64'(done1_cyc[1] - done1_cyc[0]), 64'd35);
        checkOutput("t1_done_period_b", 64'(done1_cyc[2] - done1_cyc[1]), 64'd35);
        checkOutput("t1_pv_at_third_done", 64'(done1_pv[2]), 64'd105);
        checkOutput("t1_pv_continuous", 64'(pv1_cyc[104] - pv1_cyc[0]), 64'd104);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
